decoder_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 3-to-8 one-hot decoder resource among 8 requesters.
- Selects one requester and holds its index, which drives the decoded one-hot grant bus until the owner signals completion.
- Sits between request sources (switches or upstream logic) and the decoded output lines (LEDs or enables).
- Optional hold timeout forcibly reclaims the resource from an owner that stalls.

---
 rtl/decoder_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares a 3-to-8 one-hot decoder among 8
//   requesters. A winner is chosen from IDLE and its index is held. The index
//   drives a registered one-hot grant bus until the owner signals done or
//   withdraws its request. After every grant there is at least one cycle with
//   no grant. The search pointer then moves to the slot after the last owner.
//
// Optional feature (macro DECODER_ARB_TIMEOUT_EN):
//   When defined, a grant that lasts HOLD_MAX cycles without a release is
//   reclaimed. The release happens as normal, and timeout pulses high for the
//   idle cycle that follows. When undefined, timeout is tied to 0.
//
// Parameters:
//   HOLD_MAX  maximum grant length in cycles before forced release (1..255)
//   CNT_W     hold counter width; 2**CNT_W must exceed HOLD_MAX
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous active-high reset
//   enable     in   1  arbitration enable (new grants only)
//   req        in   8  request vector
//   done       in   1  owner releases the resource (used only while granted)
//   gnt        out  8  registered one-hot grant, zero when no grant
//   gnt_idx    out  3  index of current or last owner
//   gnt_valid  out  1  a grant is active
//   timeout    out  1  one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  // At this count the increment taken this cycle would reach HOLD_MAX. The
  // grant has then been visible for exactly HOLD_MAX cycles.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [2:0]       ptr_reg, ptr_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       gnt_reg, gnt_next;
  logic             timeout_reg, timeout_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Request vector rotated so that bit 0 is the slot at the search pointer.
  logic [7:0] req_rot;
  logic [2:0] win_off;
  logic [2:0] winner;
  logic       release_now;
  logic       at_limit;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = req[ptr_reg + 3'(gi)];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the first requester at or after
  // ptr. The descending scan leaves the lowest index as the final value.
  always_comb begin
    win_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (req_rot[k]) win_off = 3'(k);
    end
  end

  assign winner      = ptr_reg + win_off;
  assign release_now = done || !req[idx_reg];
  assign at_limit    = (cnt_reg >= HOLD_LAST);

`ifndef DECODER_ARB_TIMEOUT_EN
  // The limit only matters when forced release is built in.
  logic unused_limit;
  assign unused_limit = at_limit;
`endif

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    idx_next     = idx_reg;
    gnt_next     = gnt_reg;
    cnt_next     = cnt_reg;
    timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable && (|req)) begin
          state_next = GRANT;
          idx_next   = winner;
          gnt_next   = 8'h01 << winner;
          cnt_next   = '0;
        end
      end

      GRANT: begin
        if (release_now) begin
          state_next = IDLE;
          ptr_next   = idx_reg + 3'd1;
          gnt_next   = 8'h00;
`ifdef DECODER_ARB_TIMEOUT_EN
        end else if (at_limit) begin
          // A done or withdrawal in the same cycle takes the branch above,
          // so timeout marks only a true stall.
          state_next   = IDLE;
          ptr_next     = idx_reg + 3'd1;
          gnt_next     = 8'h00;
          timeout_next = 1'b1;
`endif
        end else if (cnt_reg != CNT_SAT) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        gnt_next   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= 3'd0;
      idx_reg     <= 3'd0;
      gnt_reg     <= 8'h00;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      idx_reg     <= idx_next;
      gnt_reg     <= gnt_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = idx_reg;
  assign gnt_valid = (state_reg == GRANT);
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_decoder_rr_arbiter
//
// Self-checking bench for decoder_rr_arbiter, built with HOLD_MAX=4.
// An independent cycle model predicts {gnt, gnt_idx, gnt_valid, timeout} at
// each rising edge and pushes the prediction onto a scoreboard queue. The
// value is popped and compared on the following falling edge. Directed checks
// from the test scenarios are also made on top of the scoreboard comparison.
// Set DECODER_ARB_TIMEOUT_EN for both files to cover forced release.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_rr_arbiter;

  localparam int HOLD_MAX = 4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  decoder_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard entries hold {gnt, gnt_idx, gnt_valid, timeout}.
  logic [12:0] exp_q[$];

  // Reference model state
  bit m_valid;
  int m_ptr;
  int m_idx;
  int m_cnt;
  bit m_to;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_gnt();
    logic [7:0] g;
    g = 8'h00;
    if (m_valid) g[m_idx] = 1'b1;
    return g;
  endfunction

  // Prediction of the next state, using the inputs sampled at this edge.
  task automatic model_step();
    bit rel;
    bit forced;
    if (rst) begin
      m_valid = 0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_to = 0;
    end else if (!m_valid) begin
      m_to = 0;
      if (enable && req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            break;
          end
        end
        m_valid = 1;
        m_cnt   = 0;
      end
    end else begin
      m_to   = 0;
      rel    = done || !req[m_idx];
      forced = 0;
`ifdef DECODER_ARB_TIMEOUT_EN
      if (!rel && (m_cnt + 1 >= HOLD_MAX)) forced = 1;
`endif
      if (rel || forced) begin
        m_valid = 0;
        m_ptr   = (m_idx + 1) % 8;
        m_to    = forced;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
    end
  endtask

  // One clock: the model predicts at the edge, and the scoreboard compares at
  // the falling edge. Inputs are changed by the caller after return.
  task automatic tick();
    logic [12:0] exp_v;
    @(posedge clk);
    model_step();
    exp_q.push_back({model_gnt(), 3'(m_idx), m_valid, m_to});
    @(negedge clk);
    exp_v = exp_q.pop_front();
    check_val("sb_outputs", {19'd0, gnt, gnt_idx, gnt_valid, timeout}, {19'd0, exp_v});
  endtask

  task automatic expect_gnt(input string tag, input logic [7:0] g, input logic [2:0] idx,
                            input logic v, input logic t);
    $display("TX %s gnt=0x%02h idx=%0d valid=%0b timeout=%0b", tag, gnt, gnt_idx, gnt_valid, timeout);
    check_val({tag, "_gnt"}, {24'd0, gnt}, {24'd0, g});
    check_val({tag, "_idx"}, {29'd0, gnt_idx}, {29'd0, idx});
    check_val({tag, "_valid"}, {31'd0, gnt_valid}, {31'd0, v});
    check_val({tag, "_timeout"}, {31'd0, timeout}, {31'd0, t});
  endtask

  initial begin
    logic [7:0] exp_g;
    rst = 1'b1; enable = 1'b0; req = 8'h00; done = 1'b0;
    m_valid = 0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_to = 0;

    // Reset, then idle
    @(negedge clk);
    tick(); tick();
    expect_gnt("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0; enable = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    expect_gnt("idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // Single request, then ptr advance verified via req 0x41
    req = 8'h20;
    tick();
    expect_gnt("single", 8'h20, 3'd5, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    expect_gnt("single_rel", 8'h00, 3'd5, 1'b0, 1'b0);
    done = 1'b0; req = 8'h41;
    tick();
    expect_gnt("ptr6", 8'h40, 3'd6, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0; req = 8'h00;

    // Round-robin wrap from ptr 0 with all requesting
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 8'hFF; done = 1'b1;
    for (int n = 0; n < 9; n++) begin
      tick();
      exp_g = 8'h01 << (n % 8);
      expect_gnt("rr", exp_g, 3'(n % 8), 1'b1, 1'b0);
      tick();
      check_val("rr_gap", {24'd0, gnt}, 32'd0);
    end
    done = 1'b0; req = 8'h00;
    tick();

    // Enable gating and withdrawal (ptr is now 1)
    enable = 1'b0; req = 8'h08;
    for (int c = 0; c < 3; c++) tick();
    expect_gnt("en_off", 8'h00, 3'd0, 1'b0, 1'b0);
    enable = 1'b1;
    tick();
    expect_gnt("en_on", 8'h08, 3'd3, 1'b1, 1'b0);
    enable = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    expect_gnt("en_hold", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    tick();
    expect_gnt("withdraw", 8'h00, 3'd3, 1'b0, 1'b0);

    // Reset mid-grant, then ptr must be back at 0
    enable = 1'b1; req = 8'h10;
    tick();
    expect_gnt("pre_rst", 8'h10, 3'd4, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    expect_gnt("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0; req = 8'h11;
    tick();
    expect_gnt("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;
    tick();

    // Hold timeout
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 8'h03;
`ifdef DECODER_ARB_TIMEOUT_EN
    for (int c = 0; c < HOLD_MAX; c++) begin
      tick();
      expect_gnt("to_hold", 8'h01, 3'd0, 1'b1, 1'b0);
    end
    tick();
    expect_gnt("to_fire", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    expect_gnt("to_next", 8'h02, 3'd1, 1'b1, 1'b0);
`else
    for (int c = 0; c < 100; c++) tick();
    expect_gnt("no_to", 8'h01, 3'd0, 1'b1, 1'b0);
`endif
    req = 8'h00;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
